// File: rtl/elevador_pkg.sv
// Shared definitions for the three-floor elevator sequencer.
//   state_t : controller states (IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3)
//   dir_t   : remembered travel direction (UP/DOWN)
//   FLOOR_MIN / FLOOR_MAX : legal floor range
//   floor_bit / above_mask / below_mask : call-vector helpers for a floor
package elevador_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  localparam logic [1:0] FLOOR_MIN = 2'd0;
  localparam logic [1:0] FLOOR_MAX = 2'd2;

  function automatic logic [2:0] floor_bit(input logic [1:0] f);
    logic [2:0] m;
    case (f)
      2'd0:    m = 3'b001;
      2'd1:    m = 3'b010;
      2'd2:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] above_mask(input logic [1:0] f);
    logic [2:0] m;
    case (f)
      2'd0:    m = 3'b110;
      2'd1:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] below_mask(input logic [1:0] f);
    logic [2:0] m;
    case (f)
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/elevador_tick_timer.sv
// Tick-enabled interval timer shared by travel and door timing.
//   clk, rst : system clock, async active-high reset
//   tick     : clock-enable pulse; the count advances only on tick
//   clear    : synchronous clear, holds the count at 0 and masks done
//   limit    : terminal count (interval length minus one)
//   done     : combinational pulse on the tick that reaches limit;
//              the count wraps to 0 on that same edge
module elevador_tick_timer #(
  parameter int unsigned TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          clear,
  input  logic [TW-1:0] limit,
  output logic          done
);

  logic [TW-1:0] count;

  assign done = tick && !clear && (count == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || done) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/elevador_ctrl_3p.sv
// Three-floor elevator sequencer: latches calls, schedules travel with a
// direction-preference sweep, and drives registered motor/door outputs.
// Optional macro ELEV_DOOR_SENSOR_EN adds input door_block, which holds the
// door open (timer pinned at 0) while asserted.
//   clk, rst   : system clock, async active-high reset
//   tick       : one-cycle clock enable from the frequency divider
//   req[2:0]   : floor call buttons, OR-latched into pending
//   door_block : (ELEV_DOOR_SENSOR_EN only) door obstruction sensor
//   floor[1:0] : current floor 0..2
//   motor_up, motor_down, door_open : one-hot with the active state
//   pending    : latched outstanding calls
//   busy       : high whenever not IDLE
module elevador_ctrl_3p
  import elevador_pkg::*;
#(
  parameter int unsigned TRAVEL_TICKS = 4,
  parameter int unsigned DOOR_TICKS   = 3,
  parameter int unsigned TW           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] req,
`ifdef ELEV_DOOR_SENSOR_EN
  input  logic       door_block,
`endif
  output logic [1:0] floor,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic [2:0] pending,
  output logic       busy
);

  localparam logic [TW-1:0] TRAVEL_LIM = TW'(TRAVEL_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LIM   = TW'(DOOR_TICKS - 1);

  state_t        state, state_nxt;
  dir_t          dir, dir_nxt;
  logic [1:0]    floor_nxt;
  logic [2:0]    calls;
  logic [2:0]    clr_mask;
  logic [2:0]    pending_nxt;
  logic          door_hold;
  logic          tmr_clear;
  logic          tmr_done;
  logic [TW-1:0] tmr_limit;

`ifdef ELEV_DOOR_SENSOR_EN
  assign door_hold = door_block;
`else
  assign door_hold = 1'b0;
`endif

  // Requests arriving this cycle take part in every decision made this cycle.
  assign calls = pending | req;

  // Timer is pinned at 0 in IDLE; in DOOR_OPEN a fresh call for this floor
  // or an obstruction restarts the full door interval. Kept independent of
  // tmr_done so there is no combinational loop through the timer.
  assign tmr_clear = (state == IDLE) ||
                     ((state == DOOR_OPEN) && ((|(req & floor_bit(floor))) || door_hold));

  assign tmr_limit = (state == DOOR_OPEN) ? DOOR_LIM : TRAVEL_LIM;

  elevador_tick_timer #(
    .TW(TW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .clear(tmr_clear),
    .limit(tmr_limit),
    .done (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    floor_nxt = floor;
    case (state)
      IDLE: begin
        if (|(calls & floor_bit(floor))) begin
          state_nxt = DOOR_OPEN;
        end else if ((dir == UP) && (|(calls & above_mask(floor)))) begin
          state_nxt = MOVE_UP;
        end else if (|(calls & below_mask(floor))) begin
          state_nxt = MOVE_DOWN;
          dir_nxt   = DOWN;
        end else if (|(calls & above_mask(floor))) begin
          state_nxt = MOVE_UP;
          dir_nxt   = UP;
        end
      end
      MOVE_UP: begin
        if (tmr_done) begin
          if (floor == FLOOR_MAX) begin
            state_nxt = IDLE;
          end else begin
            floor_nxt = floor + 2'd1;
            if (|(calls & floor_bit(floor_nxt))) begin
              state_nxt = DOOR_OPEN;
            end else if (|(calls & above_mask(floor_nxt))) begin
              state_nxt = MOVE_UP;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      MOVE_DOWN: begin
        if (tmr_done) begin
          if (floor == FLOOR_MIN) begin
            state_nxt = IDLE;
          end else begin
            floor_nxt = floor - 2'd1;
            if (|(calls & floor_bit(floor_nxt))) begin
              state_nxt = DOOR_OPEN;
            end else if (|(calls & below_mask(floor_nxt))) begin
              state_nxt = MOVE_DOWN;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      DOOR_OPEN: begin
        if (tmr_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The served floor's call is dropped while the door is open and on the
  // very cycle the door is entered (using the arrival floor).
  always_comb begin
    clr_mask = '0;
    if ((state == DOOR_OPEN) || (state_nxt == DOOR_OPEN)) begin
      clr_mask = floor_bit(floor_nxt);
    end
    pending_nxt = calls & ~clr_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= UP;
      floor      <= FLOOR_MIN;
      pending    <= '0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door_open  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      floor      <= floor_nxt;
      pending    <= pending_nxt;
      motor_up   <= (state_nxt == MOVE_UP);
      motor_down <= (state_nxt == MOVE_DOWN);
      door_open  <= (state_nxt == DOOR_OPEN);
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_elevador_ctrl_3p.sv
// Scoreboard bench for elevador_ctrl_3p: the stimulus side predicts the
// sequence of stops with a sweep model and queues them; the monitor checks
// each door opening (floor, travel ticks, remaining calls) and each closing.
module tb_elevador_ctrl_3p;

  localparam int TT = 4;
  localparam int DT = 3;

  typedef struct {
    int fl;
    int ticks;
  } stop_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] req = 3'b000;
  logic [1:0] floor;
  logic       motor_up, motor_down, door_open, busy;
  logic [2:0] pending;
`ifdef ELEV_DOOR_SENSOR_EN
  logic       door_block = 1'b0;
`else
  logic       door_block;
  assign door_block = 1'b0;
`endif

  int tests = 0;
  int failed = 0;
  stop_t exp_q[$];
  int mfloor = 0;
  bit mdir_up = 1'b1;

  elevador_ctrl_3p #(
    .TRAVEL_TICKS(TT),
    .DOOR_TICKS  (DT),
    .TW          (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .req       (req),
`ifdef ELEV_DOOR_SENSOR_EN
    .door_block(door_block),
`endif
    .floor     (floor),
    .motor_up  (motor_up),
    .motor_down(motor_down),
    .door_open (door_open),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Frequency-divider stand-in: one-clock pulses with random spacing.
  initial begin
    forever begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Sweep model: serve the current floor, else keep going in the remembered
  // direction while calls remain that way, otherwise reverse.
  task automatic push_batch(input logic [2:0] m);
    bit s[3];
    bit up_any, dn_any;
    int tgt;
    for (int i = 0; i < 3; i++) s[i] = m[i];
    while (s[0] || s[1] || s[2]) begin
      if (s[mfloor]) begin
        exp_q.push_back('{fl: mfloor, ticks: 0});
        s[mfloor] = 1'b0;
      end else begin
        up_any = 1'b0;
        dn_any = 1'b0;
        for (int i = 0; i < 3; i++) begin
          if (s[i] && i > mfloor) up_any = 1'b1;
          if (s[i] && i < mfloor) dn_any = 1'b1;
        end
        tgt = mfloor;
        if ((mdir_up && up_any) || !dn_any) begin
          mdir_up = 1'b1;
          for (int i = 2; i > mfloor; i--) if (s[i]) tgt = i;
        end else begin
          mdir_up = 1'b0;
          for (int i = 0; i < mfloor; i++) if (s[i]) tgt = i;
        end
        exp_q.push_back('{fl: tgt, ticks: (tgt > mfloor ? tgt - mfloor : mfloor - tgt) * TT});
        mfloor = tgt;
        s[tgt] = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic [2:0] m);
    @(posedge clk);
    #1 req = m;
    @(posedge clk);
    #1 req = 3'b000;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || pending != 3'b000 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(n >= budget), 0);
  endtask

  task automatic wait_ticks(input int k);
    int n = 0;
    int seen = 0;
    while (seen < k && n < 1000) begin
      @(negedge clk);
      if (tick) seen++;
      n++;
    end
    chk("tick_timeout", int'(n >= 1000), 0);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each door opening.
  initial begin
    int mcnt = 0;
    int dcnt = 0;
    int last_fl = 0;
    logic prev_do = 1'b0;
    logic [2:0] rem;
    stop_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mcnt = 0;
        dcnt = 0;
        prev_do = 1'b0;
        continue;
      end
      chk("outputs_exclusive",
          int'((motor_up && motor_down) || (motor_up && door_open) || (motor_down && door_open)), 0);
      chk("busy_vs_outputs", int'(busy), int'(motor_up || motor_down || door_open));
      chk("floor_range", int'(floor <= 2'd2), 1);
      if (tick && (motor_up || motor_down)) mcnt++;
      if (door_open && !prev_do) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_stop: door opened at floor %0d, no stop expected", floor);
        end else begin
          e = exp_q.pop_front();
          rem = 3'b000;
          foreach (exp_q[i]) rem[exp_q[i].fl] = 1'b1;
          chk("stop_floor", int'(floor), e.fl);
          chk("travel_ticks", mcnt, e.ticks);
          chk("pending_at_stop", int'(pending), int'(rem));
          last_fl = e.fl;
        end
        mcnt = 0;
        dcnt = 0;
      end
      if (!door_open && prev_do) chk("door_ticks", dcnt, DT);
      if (door_open) begin
        if (req[last_fl] || door_block) dcnt = 0;
        else if (tick) dcnt++;
      end
      prev_do = door_open;
    end
  end

  initial begin
    int n;
    logic [2:0] m;

    // Reset then idle for 50 ticks.
    #10 rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      wait_ticks(1);
      chk("idle_quiet", int'({floor, motor_up, motor_down, door_open, busy, pending}), 0);
    end

    // Call at current floor: door opens on the next clock.
    push_batch(3'b001);
    @(posedge clk);
    #1 req = 3'b001;
    @(posedge clk);
    #1;
    chk("same_floor_door", int'(door_open), 1);
    chk("same_floor_pending", int'(pending), 0);
    req = 3'b000;
    wait_idle(500);

    // Two-floor trip without an intermediate stop.
    push_batch(3'b100);
    issue(3'b100);
    wait_idle(1000);
    chk("trip_floor", int'(floor), 2);

    // Direction preference: 2->1, then 1 with dir UP, then calls 0 and 2.
    push_batch(3'b010);
    issue(3'b010);
    wait_idle(1000);
    push_batch(3'b001);
    issue(3'b001);
    wait_idle(1000);
    push_batch(3'b010);
    issue(3'b010);
    wait_idle(1000);
    push_batch(3'b101);
    issue(3'b101);
    wait_idle(1000);
    chk("pref_end_floor", int'(floor), 0);

    // Door re-open at floor 2.
    push_batch(3'b100);
    issue(3'b100);
    n = 0;
    while (!door_open && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reopen_reach_timeout", int'(n >= 1000), 0);
    wait_ticks(1);
    @(posedge clk);
    #1 req = 3'b100;
    @(posedge clk);
    #1 req = 3'b000;
    chk("reopen_still_open", int'(door_open), 1);
    chk("reopen_pending", int'(pending), 0);
    wait_idle(1000);

`ifdef ELEV_DOOR_SENSOR_EN
    // Obstructed door stays open, then closes on a full countdown.
    m = 3'b001 << mfloor;
    push_batch(m);
    door_block = 1'b1;
    issue(m);
    wait_ticks(10);
    chk("blocked_open", int'(door_open), 1);
    door_block = 1'b0;
    wait_idle(1000);
`endif

    // Randomized call batches.
    for (int b = 0; b < 25; b++) begin
      m = 3'($urandom_range(1, 7));
      push_batch(m);
      issue(m);
      wait_idle(3000);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    // Reset while moving down.
    if (mfloor == 0) begin
      push_batch(3'b100);
      issue(3'b100);
      wait_idle(1000);
    end
    push_batch(3'b001);
    issue(3'b001);
    n = 0;
    while (!motor_down && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("motor_down_timeout", int'(n >= 1000), 0);
    #2 rst = 1'b1;
    exp_q.delete();
    mfloor = 0;
    mdir_up = 1'b1;
    #1;
    chk("async_reset", int'({floor, motor_up, motor_down, door_open, busy, pending}), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Floor 0 is authoritative after reset.
    push_batch(3'b010);
    issue(3'b010);
    wait_idle(1000);
    chk("post_reset_floor", int'(floor), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
